// File: rtl/demux_pkg.sv
// Shared types and sizing for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_t;

endpackage

// File: rtl/demux_1_4_stream_out_slot.sv
// One-entry output register slice: holds a beat until its sink takes it.
module out_slot #(
    parameter int DATA_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              load_en,
    input  logic [DATA_W-1:0] d,
    input  logic              last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last_flag
);

    // A load wins over a drain, which gives back-to-back beats at full rate.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid     <= 1'b0;
            data      <= '0;
            last_flag <= 1'b0;
        end else if (load_en) begin
            valid     <= 1'b1;
            data      <= d;
            last_flag <= last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_4_stream.sv
// Packet router: steers one valid/ready stream to one of four registered sinks.
//
// state | meaning
// IDLE  | between packets; sel_in picks the destination of the next beat
// ROUTE | mid-packet; beats go to route_q until last_in is accepted
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [DATA_W-1:0]         d_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      last_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    output logic [NUM_OUT*DATA_W-1:0] y_out,
    output logic [NUM_OUT-1:0]        valid_out,
    output logic [NUM_OUT-1:0]        last_out,
    input  logic [NUM_OUT-1:0]        ready_in,
    output logic                      busy_out
);

    state_t             state_q;
    logic [SEL_W-1:0]   route_q;
    logic [SEL_W-1:0]   tgt;
    logic               accept;
    logic [NUM_OUT-1:0] load_en;

    assign tgt       = (state_q == IDLE) ? sel_in : route_q;
    assign ready_out = !valid_out[tgt] || ready_in[tgt];
    assign accept    = valid_in && ready_out;
    assign busy_out  = (state_q == ROUTE);

    always_comb begin
        load_en = '0;
        if (accept) begin
            load_en[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            route_q <= '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!last_in) begin
                        state_q <= ROUTE;
                        route_q <= sel_in;
                    end
                end
                ROUTE: begin
                    if (last_in) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
        out_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .load_en   (load_en[i]),
            .d         (d_in),
            .last      (last_in),
            .ready     (ready_in[i]),
            .valid     (valid_out[i]),
            .data      (y_out[i*DATA_W +: DATA_W]),
            .last_flag (last_out[i])
        );
    end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Bench for demux_1_4_stream: directed scenarios plus random traffic against a packet-level model.
module tb_demux_1_4_stream;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  d_in;
    logic [1:0]  sel_in;
    logic        last_in;
    logic        valid_in;
    logic        ready_out;
    logic [15:0] y_out;
    logic [3:0]  valid_out;
    logic [3:0]  last_out;
    logic [3:0]  ready_in;
    logic        busy_out;

    int checks   = 0;
    int failures = 0;

    // Model: contents of each sink slot and the open-packet context.
    bit         m_valid [4];
    logic [3:0] m_data  [4];
    bit         m_last  [4];
    bit         m_in_pkt;
    int         m_dest;
    bit         tb_acc;

    always #5 clk_in = ~clk_in;

    demux_1_4_stream #(.DATA_W(4)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .d_in      (d_in),
        .sel_in    (sel_in),
        .last_in   (last_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .y_out     (y_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .ready_in  (ready_in),
        .busy_out  (busy_out)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 4'h0;
            m_last[i]  = 1'b0;
        end
        m_in_pkt = 1'b0;
        m_dest   = 0;
    endtask

    // One clock: check ready_out before the edge, advance the model, check outputs after.
    task automatic tick();
        int         t;
        bit         rdy;
        bit         rst_s;
        logic [3:0] d_s;
        bit         last_s;
        logic [3:0] rin_s;
        logic [3:0]  e_valid;
        logic [3:0]  e_last;
        logic [15:0] e_y;
        #1;
        t      = m_in_pkt ? m_dest : int'(sel_in);
        rdy    = !m_valid[t] || ready_in[t];
        chk("ready_out", 16'(ready_out), 16'(rdy));
        tb_acc = valid_in && rdy;
        rst_s  = rst_in;
        d_s    = d_in;
        last_s = last_in;
        rin_s  = ready_in;
        @(posedge clk_in);
        if (rst_s) begin
            model_reset();
            tb_acc = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (tb_acc && i == t) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = d_s;
                    m_last[i]  = last_s;
                end else if (m_valid[i] && rin_s[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (tb_acc) begin
                if (!m_in_pkt && !last_s) begin
                    m_in_pkt = 1'b1;
                    m_dest   = t;
                end else if (m_in_pkt && last_s) begin
                    m_in_pkt = 1'b0;
                end
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            e_valid[i]       = m_valid[i];
            e_last[i]        = m_last[i];
            e_y[i*4 +: 4]    = m_data[i];
        end
        chk("valid_out", 16'(valid_out), 16'(e_valid));
        chk("y_out", y_out, e_y);
        chk("last_out", 16'(last_out), 16'(e_last));
        chk("busy_out", 16'(busy_out), 16'(m_in_pkt));
    endtask

    task automatic beat(input logic [3:0] d, input logic [1:0] s, input bit l);
        valid_in = 1'b1;
        d_in     = d;
        sel_in   = s;
        last_in  = l;
        tick();
    endtask

    initial begin
        int busy_cycles;
        rst_in   = 1'b1;
        d_in     = '0;
        sel_in   = '0;
        last_in  = 1'b0;
        valid_in = 1'b0;
        ready_in = 4'b1111;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // 1: idle after reset
        tick();
        chk("t1_valid", 16'(valid_out), 16'h0);
        chk("t1_y", y_out, 16'h0);
        chk("t1_ready", 16'(ready_out), 16'h1);

        // 2: single-beat packet to channel 2
        beat(4'hA, 2'd2, 1'b1);
        chk("t2_valid", 16'(valid_out), 16'h4);
        chk("t2_y2", 16'(y_out[11:8]), 16'hA);
        chk("t2_last2", 16'(last_out[2]), 16'h1);
        chk("t2_busy", 16'(busy_out), 16'h0);
        valid_in = 1'b0;
        tick();

        // 3: three beats to ch1; sel_in changes mid-packet and must be ignored
        busy_cycles = 0;
        beat(4'h1, 2'd1, 1'b0);
        busy_cycles += int'(busy_out);
        chk("t3_b1", 16'({valid_out[1], y_out[7:4], last_out[1]}), 16'({1'b1, 4'h1, 1'b0}));
        beat(4'h2, 2'd3, 1'b0);
        busy_cycles += int'(busy_out);
        chk("t3_b2", 16'({valid_out[1], y_out[7:4], last_out[1]}), 16'({1'b1, 4'h2, 1'b0}));
        beat(4'h3, 2'd3, 1'b1);
        busy_cycles += int'(busy_out);
        chk("t3_b3", 16'({valid_out[1], y_out[7:4], last_out[1]}), 16'({1'b1, 4'h3, 1'b1}));
        chk("t3_ch3", 16'(valid_out[3]), 16'h0);
        chk("t3_busy_cnt", 16'(busy_cycles), 16'd2);
        valid_in = 1'b0;
        tick();

        // 4: back-pressure on ch0, then release
        ready_in = 4'b1110;
        beat(4'h5, 2'd0, 1'b0);
        d_in    = 4'h6;
        last_in = 1'b1;
        tick();
        chk("t4_hold_y0", 16'(y_out[3:0]), 16'h5);
        chk("t4_ready_lo", 16'(ready_out), 16'h0);
        ready_in = 4'b1111;
        tick();
        chk("t4_valid0", 16'(valid_out[0]), 16'h1);
        chk("t4_y0", 16'(y_out[3:0]), 16'h6);
        valid_in = 1'b0;
        tick();

        // 5: ch0 stalled while a packet flows to ch3
        ready_in = 4'b1110;
        beat(4'h7, 2'd0, 1'b1);
        beat(4'h8, 2'd3, 1'b0);
        beat(4'h9, 2'd0, 1'b0);
        beat(4'hB, 2'd0, 1'b1);
        chk("t5_y3", 16'(y_out[15:12]), 16'hB);
        chk("t5_y0", 16'({valid_out[0], y_out[3:0]}), 16'h17);
        valid_in = 1'b0;
        ready_in = 4'b1111;
        tick();

        // 6: reset mid-packet, then a fresh beat must follow sel_in
        beat(4'h1, 2'd2, 1'b0);
        beat(4'h2, 2'd2, 1'b0);
        valid_in = 1'b0;
        rst_in   = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("t6_valid", 16'(valid_out), 16'h0);
        chk("t6_busy", 16'(busy_out), 16'h0);
        beat(4'hC, 2'd0, 1'b1);
        chk("t6_route", 16'(valid_out), 16'h1);
        chk("t6_y0", 16'(y_out[3:0]), 16'hC);
        valid_in = 1'b0;
        tick();

        // Random traffic; source holds its beat until accepted
        for (int n = 0; n < 600; n++) begin
            rst_in = ($urandom_range(0, 79) == 0);
            if (!(valid_in && !tb_acc) || rst_in) begin
                valid_in = ($urandom_range(0, 3) != 0);
                d_in     = 4'($urandom);
                sel_in   = 2'($urandom);
                last_in  = ($urandom_range(0, 2) == 0);
            end
            ready_in = 4'($urandom);
            tick();
        end
        rst_in   = 1'b0;
        valid_in = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
Packet-routing 1-to-4 demultiplexer: the distribution-side counterpart of the 4:1 mux. It steers a valid/ready stream from one source to one of four sinks. The destination is chosen by sel_in on the first beat of each packet and is held until the beat flagged last_in. Each output has a one-entry register slot, so sinks back-pressure independently and latency is one cycle.

Parameters:
DATA_W, 4, width of each data beat
NUM_OUT, 4, number of output channels (fixed at 4; sel width 2)

Ports:
clk_in  input  1  clock, all logic on rising edge
rst_in  input  1  reset; synchronous, active-high
d_in  input  DATA_W  input beat data
sel_in  input  2  destination channel; sampled only on the first beat of a packet
last_in  input  1  marks final beat of packet
valid_in  input  1  input beat valid
ready_out  output  1  block can accept the beat this cycle
y_out  output  4*DATA_W  packed output data; channel i at [i*DATA_W +: DATA_W]
valid_out  output  4  per-channel output valid
last_out  output  4  per-channel last flag, aligned with y_out slice
ready_in  input  4  per-channel sink ready
busy_out  output  1  high while mid-packet (state ROUTE)

Behaviour:
- Reset (rst_in=1 at clock edge): state=IDLE, route_q=0, valid_out=0, last_out=0, y_out=0, busy_out=0. Reset mid-packet discards buffered beats and the packet context; no partial flush.
- Target channel t = (state==IDLE) ? sel_in : route_q.
- ready_out = !valid_out[t] || ready_in[t]. This is combinational on sel_in (IDLE), route_q and ready_in; no path from valid_in.
- Accept = valid_in && ready_out. On accept: slot t loads d_in and last_in, and valid_out[t]=1 next cycle. Latency is exactly 1 cycle.
- FSM, state IDLE:
  - Accept with last_in=1 → stay IDLE (single-beat packet).
  - Accept with last_in=0 → route_q<=sel_in, go to ROUTE.
  - No accept → stay IDLE.
- FSM, state ROUTE: sel_in is ignored. Accept with last_in=1 → IDLE. Otherwise stay in ROUTE.
- busy_out = (state==ROUTE), registered.
- Slot i drains when valid_out[i] && ready_in[i].
  - Drain with a simultaneous load of the same slot → valid stays 1 with the new data (full throughput, 1 beat/clk).
  - Drain only → valid_out[i]=0. y_out/last_out slice keeps its last value (don't-care while invalid; no clear required).
- While valid_out[i]=1 and ready_in[i]=0, the y_out slice and last_out[i] must hold stable.
- Non-target slots are never written. They drain independently in the same cycle as a load to another slot.
- valid_in with ready_out=0: nothing is captured. Source must hold d_in, sel_in and last_in stable (standard valid/ready rule). The block does not check this.
- ready_in to a channel with valid_out=0 has no effect.
- No packet interleaving: the next packet starts only after the last beat of the current one is accepted. Its destination may be any channel, including the same one.

Decomposition:
- Package demux_pkg: NUM_OUT=4, SEL_W=2, enum state_t {IDLE, ROUTE}.
- Sub-module out_slot: one-entry register slice with load/drain/valid/data/last and synchronous active-high reset on clk_in/rst_in; instantiated 4x via generate.
- Top level holds the FSM, route_q, ready_out mux and load-enable decode.

Test Plan:
1. Reset then idle, all ready_in=4'b1111 → valid_out=0, last_out=0, y_out=0, busy_out=0, ready_out=1.
2. Single beat d_in=4'hA, sel_in=2, last_in=1 at cycle N → cycle N+1: valid_out=4'b0100, y_out[11:8]=4'hA, last_out[2]=1, busy_out=0.
3. 3-beat packet 1,2,3 with sel_in=1 on beat 1, then sel_in changed to 3 on beats 2-3, ready_in=1111 → all three beats appear on channel 1 on consecutive cycles; last_out[1]=1 only with data 3; busy_out=1 for exactly 2 cycles; channel 3 untouched.
4. Back-pressure: ready_in[0]=0, send 2 beats to ch0 → first beat lands and holds stable; ready_out=0 on the second. Raise ready_in[0] → same cycle ready_out=1, second beat loads as first drains, valid_out[0] stays 1.
5. Independent drain: ch0 full with ready_in[0]=0, packet to ch3 → ch3 beats flow at full rate while ch0 holds its value.
6. Mid-packet reset after 2 of 4 beats to ch2 → next cycle valid_out=0, busy_out=0, state IDLE. A new single beat with sel_in=0 routes to ch0, not ch2.
